result_serializer_6: RTL and testbench
======================================

RESULT_SERIALIZER_6 -- requirements
Module: result_serializer_6

Interface
REQ-001 Parameter NWORDS, default 6: number of result words per capture.
REQ-002 Parameter DW, default 32: width of each result word in bits.
REQ-003 The clock port SHALL be clk, input, 1 bit: the single clock; all state is rising-edge clocked.
REQ-004 The reset port SHALL be rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 Port res_valid SHALL be an input, 1 bit, driven by the level-valid output of the row-sum adder tree.
REQ-006 Port res_in SHALL be an input, NWORDS*DW bits, carrying the packed row sums, with word k at bits [k*DW +: DW].
REQ-007 Port m_data SHALL be an output, DW bits: the current output word.
REQ-008 Port m_valid SHALL be an output, 1 bit: m_data holds a word.
REQ-009 Port m_ready SHALL be an input, 1 bit: the downstream sink accepts the word.
REQ-010 Port m_last SHALL be an output, 1 bit: the current word is word NWORDS-1.
REQ-011 Port busy SHALL be an output, 1 bit: the block is in state SEND.
REQ-012 Port ovf SHALL be an output, 1 bit: sticky flag for a result that was dropped.
REQ-013 Port ovf_clr SHALL be an input, 1 bit: synchronous clear for ovf.

Function
REQ-014 Capture event: res_valid sampled 1 while the registered previous sample res_valid_q is 0 (rising edge).
REQ-015 The FSM SHALL have two states, IDLE and SEND.
REQ-016 In IDLE, a capture event SHALL:
- latch res_in into a shadow register;
- set idx=0;
- move the FSM to SEND.
REQ-017 Latency: capture event sampled at edge N -> m_valid=1 after edge N, with m_data = shadow word 0.
REQ-018 In SEND, m_valid=1 and m_data = shadow[idx*DW +: DW].
REQ-019 In SEND, m_last=1 exactly when idx==NWORDS-1; otherwise m_last=0.
REQ-020 Transfer occurs when m_valid & m_ready; on a transfer with idx<NWORDS-1, idx SHALL increment.
REQ-021 On a transfer with idx==NWORDS-1, the FSM SHALL return to IDLE, m_valid=0.
REQ-022 While m_valid & !m_ready, m_data, m_last and idx SHALL hold unchanged.
REQ-023 A capture event in SEND that coincides with the final transfer SHALL be accepted: re-latch the shadow, set idx=0, stay in SEND (no bubble).
REQ-024 Any other capture event in SEND SHALL be dropped; the shadow register is not modified.
REQ-025 busy = (state==SEND); res_in is don't-care outside capture events.
REQ-026 idx width SHALL be clog2(NWORDS); idx never exceeds NWORDS-1.
REQ-027 No arithmetic is performed on data; words SHALL pass bit-exact.

Reset
REQ-028 While rst_n=0, the block SHALL hold:
- state=IDLE, idx=0;
- m_valid=0, m_last=0, m_data=0, busy=0, ovf=0;
- shadow register=0.
REQ-029 While rst_n=0, res_valid_q SHALL be held at 1, so a res_valid already high at reset release is not a capture event.
REQ-030 Reset asserted mid-SEND SHALL abort the transfer immediately; the remaining words are discarded.

Configuration
REQ-031 Macro RESULT_SERIALIZER_OVF_EN, when defined:
- a dropped capture (REQ-024) SHALL set ovf the next cycle;
- ovf_clr=1 SHALL clear ovf;
- set wins over simultaneous clear.
REQ-032 When RESULT_SERIALIZER_OVF_EN is undefined:
- ovf SHALL be tied 0;
- ovf_clr SHALL be ignored;
- drop behaviour per REQ-024 is unchanged.

Verification
REQ-033 Basic: res_in words 0..5 = 0x11111111..0x66666666, m_ready=1, res_valid 0->1 -> six consecutive words 0x11111111..0x66666666 starting one cycle after the edge, m_last only on 0x66666666, then m_valid=0.
REQ-034 Backpressure: m_ready toggles 1,0,0,1,... -> no word is lost or duplicated; m_data stays stable while stalled; the order is preserved.
REQ-035 Back-to-back: a second rising edge (words 0xA0..0xA5) on the final-transfer cycle -> 0xA0 follows 0x66666666 with no idle cycle.
REQ-036 Overflow (macro defined): a rising edge at word 2 -> the output sequence is unchanged, ovf=1 from the next cycle; ovf_clr pulse -> ovf=0. With the macro undefined -> ovf stays 0.
REQ-037 Reset: rst_n low during word 3 -> m_valid=0 immediately. res_valid held high across reset release -> no capture; the next 0->1 edge -> capture.

Source files
------------

// File: rtl/result_serializer_6.sv
// Captures a packed row-sum vector on each rising edge of res_valid and streams it out word by word.
// Optional sticky overflow flag for dropped captures: define RESULT_SERIALIZER_OVF_EN.
module result_serializer_6 #(
    parameter int NWORDS = 6,
    parameter int DW     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 res_valid,
    input  logic [NWORDS*DW-1:0] res_in,
    output logic [DW-1:0]        m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 busy,
    output logic                 ovf,
    input  logic                 ovf_clr
);

    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          idx_inc;
    logic [NWORDS*DW-1:0]   shadow;
    logic                   res_valid_q;
    logic                   cap;
    logic                   fin;
    logic                   load;
    logic [DW-1:0]          words [NWORDS];
    logic [DW-1:0]          next_word;

    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_words
            assign words[gi] = shadow[gi*DW +: DW];
        end
    endgenerate

    assign idx_inc   = idx + IW'(1);
    assign next_word = words[idx_inc];
    assign cap       = res_valid & ~res_valid_q;
    assign fin       = (state == SEND) & m_ready & (idx == LAST_IDX);
    // A capture is only taken when idle or on the final transfer, so the stream never bubbles.
    assign load      = cap & ((state == IDLE) | fin);
    assign m_valid   = (state == SEND);
    assign busy      = (state == SEND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            shadow      <= '0;
            m_data      <= '0;
            m_last      <= 1'b0;
            res_valid_q <= 1'b1;
        end else begin
            res_valid_q <= res_valid;
            if (load) begin
                state  <= SEND;
                shadow <= res_in;
                idx    <= '0;
                m_data <= res_in[DW-1:0];
                m_last <= (NWORDS == 1);
            end else if (state == SEND && m_ready) begin
                if (idx == LAST_IDX) begin
                    state  <= IDLE;
                    m_last <= 1'b0;
                end else begin
                    idx    <= idx_inc;
                    m_data <= next_word;
                    m_last <= (idx_inc == LAST_IDX);
                end
            end
        end
    end

`ifdef RESULT_SERIALIZER_OVF_EN
    logic drop;
    assign drop = (state == SEND) & cap & ~fin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_result_serializer_6.sv
// Bench for result_serializer_6: table vectors, directed corner sequences and a queue-based random reference.
module tb_result_serializer_6;

    localparam int NW = 6;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              res_valid;
    logic [NW*DW-1:0]  res_in;
    logic [DW-1:0]     m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              busy;
    logic              ovf;
    logic              ovf_clr;

    int errors = 0;
    int checks = 0;

    // Reference: queue of words still owed to the sink.
    logic [DW-1:0] exp_q[$];
    logic          rv_prev;
    logic          ovf_m;

    result_serializer_6 #(.NWORDS(NW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_valid (res_valid),
        .res_in    (res_in),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .busy      (busy),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rv;
        logic          rdy;
        logic          ev;
        logic [DW-1:0] ed;
        logic          el;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_words(input logic [DW-1:0] base, input logic [DW-1:0] stride);
        for (int k = 0; k < NW; k++) res_in[k*DW +: DW] = base + stride * DW'(k);
    endtask

    // One clock: update the reference from inputs seen at the edge, then compare on the falling edge.
    task automatic step();
        logic cap, was_busy, fin;
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            rv_prev = 1'b1;
            ovf_m   = 1'b0;
        end else begin
            cap      = res_valid && !rv_prev;
            rv_prev  = res_valid;
            was_busy = (exp_q.size() > 0);
            fin      = 1'b0;
            if (was_busy && m_ready) begin
                void'(exp_q.pop_front());
                fin = (exp_q.size() == 0);
            end
            if (cap && (!was_busy || fin)) begin
                for (int k = 0; k < NW; k++) exp_q.push_back(res_in[k*DW +: DW]);
            end
`ifdef RESULT_SERIALIZER_OVF_EN
            if (cap && was_busy && !fin) ovf_m = 1'b1;
            else if (ovf_clr)            ovf_m = 1'b0;
`endif
        end
        @(negedge clk);
        chk("m_valid", DW'(m_valid), DW'(exp_q.size() > 0));
        chk("busy",    DW'(busy),    DW'(exp_q.size() > 0));
        chk("ovf",     DW'(ovf),     DW'(ovf_m));
        if (exp_q.size() > 0) begin
            chk("m_data", m_data, exp_q[0]);
            chk("m_last", DW'(m_last), DW'(exp_q.size() == 1));
        end else begin
            chk("m_last_idle", DW'(m_last), '0);
        end
        if (!rst_n) chk("m_data_rst", m_data, '0);
    endtask

    task automatic wait_last(input string name);
        for (int i = 0; i < 30 && !(m_valid && m_last); i++) step();
        chk(name, DW'(m_valid && m_last), DW'(1));
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int i = 0; i < 30 && m_valid; i++) step();
        chk("drain", DW'(m_valid), '0);
    endtask

    initial begin
        rst_n = 1'b0; res_valid = 1'b0; m_ready = 1'b1; ovf_clr = 1'b0;
        res_in = '0;
        exp_q.delete(); rv_prev = 1'b1; ovf_m = 1'b0;

        // Reset state
        step(); step();
        chk("rst_valid", DW'(m_valid), '0);
        chk("rst_data",  m_data, '0);
        chk("rst_ovf",   DW'(ovf), '0);
        rst_n = 1'b1;
        step();

        // Basic burst: fixed-constant expectations
        set_words(32'h11111111, 32'h11111111);
        tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h11111111, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h22222222, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h33333333, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h44444444, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h55555555, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h66666666, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0};
        for (int i = 0; i < 9; i++) begin
            res_valid = tbl[i].rv;
            m_ready   = tbl[i].rdy;
            step();
            chk("tbl_valid", DW'(m_valid), DW'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk("tbl_data", m_data, tbl[i].ed);
                chk("tbl_last", DW'(m_last), DW'(tbl[i].el));
            end
        end

        // Backpressure: ready pattern 1,0,0,1,...
        set_words(32'h11111111, 32'h11111111);
        res_valid = 1'b1; m_ready = 1'b1;
        step();
        res_valid = 1'b0;
        for (int i = 0; i < 24; i++) begin
            logic [DW-1:0] held;
            held = m_data;
            m_ready = (i % 3 == 0);
            step();
            if (!(i % 3 == 0) && m_valid) chk("stall_hold", m_data, held);
        end
        drain();

        // Back-to-back capture on the final transfer
        set_words(32'h11111111, 32'h11111111);
        res_valid = 1'b1; m_ready = 1'b1;
        step();
        res_valid = 1'b0;
        wait_last("b2b_wait");
        chk("b2b_lastword", m_data, 32'h66666666);
        set_words(32'hA0, 32'h1);
        res_valid = 1'b1;
        step();
        chk("b2b_valid", DW'(m_valid), DW'(1));
        chk("b2b_data",  m_data, 32'hA0);
        res_valid = 1'b0;
        drain();

        // Overflow: rising edge while word 2 is on the output
        set_words(32'h11111111, 32'h11111111);
        res_valid = 1'b1;
        step();
        res_valid = 1'b0;
        step(); step();
        chk("ovf_word2", m_data, 32'h33333333);
        set_words(32'hDEAD0000, 32'h1);
        res_valid = 1'b1;
        step();
        chk("ovf_seq", m_data, 32'h44444444);
`ifdef RESULT_SERIALIZER_OVF_EN
        chk("ovf_set", DW'(ovf), DW'(1));
`else
        chk("ovf_tied", DW'(ovf), '0);
`endif
        res_valid = 1'b0;
        drain();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", DW'(ovf), '0);

        // Reset mid-burst, res_valid held high across release
        set_words(32'h11111111, 32'h11111111);
        res_valid = 1'b1;
        step(); step(); step(); step();
        chk("rst_word3", m_data, 32'h44444444);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", DW'(m_valid), '0);
        chk("rst_async_busy",  DW'(busy), '0);
        chk("rst_async_data",  m_data, '0);
        @(negedge clk);
        step();
        rst_n = 1'b1;
        step(); step(); step();
        chk("rst_nocap", DW'(m_valid), '0);
        res_valid = 1'b0;
        step();
        res_valid = 1'b1;
        step();
        chk("rst_recap", m_data, 32'h11111111);
        res_valid = 1'b0;
        drain();

        // Randomized traffic against the reference
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < NW; k++) res_in[k*DW +: DW] = $urandom();
            res_valid = ($urandom_range(0, 4) == 0);
            m_ready   = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            step();
        end
        ovf_clr = 1'b0; res_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
